// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if
//   Instruction-memory fetch bus between the IF stage and instruction memory.
//   The fetch stage drives the request side and memory answers with a one-cycle
//   acknowledge carrying the instruction word.
//
//   imem_req    fetch request, held high until imem_ack
//   imem_addr   word address of the request, stable while imem_req=1
//   imem_ack    imem_rdata is valid this cycle
//   imem_rdata  instruction word
//
//   master : fetch stage side
//   slave  : instruction memory side
// ---------------------------------------------------------------------------
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register. Holds the PC, fetches
//   words over the imem req/ack bus, and presents the fetched instruction, its
//   PC+4 and a valid bit to the decode stage. Handles decode stall (one-entry
//   park buffer) and branch redirect (flush, with a stale-ack discard when the
//   redirect lands while a request is still outstanding).
//
//   Parameters
//     RESET_PC     first fetch address after reset
//     WAIT_LIMIT   wait cycles without ack before fetch_timeout sets (>=1)
//
//   Ports
//     clk            clock, all state on rising edge
//     rst_n          synchronous active-low reset
//     stall          decode stage cannot accept; IF/ID register holds
//     redirect       branch taken; flush and refetch from redirect_pc
//     redirect_pc    redirect target (bits [1:0] ignored)
//     bus            instruction-memory bus (master side)
//     id_valid       IF/ID holds a live instruction
//     id_inst        IF/ID instruction
//     id_opcode      id_inst[31:26], to the control decoder
//     id_pc4         address of id_inst + 4
//     fetch_timeout  sticky: a request waited >= WAIT_LIMIT cycles
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  if_fetch_stage_if.master        bus,
  output logic                    id_valid,
  output logic [31:0]             id_inst,
  output logic [5:0]              id_opcode,
  output logic [31:0]             id_pc4,
  output logic                    fetch_timeout
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   req_addr_reg, req_addr_next;
  logic [31:0]   target_reg, target_next;
  logic          discard_reg, discard_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          timeout_reg, timeout_next;
  logic [31:0]   buf_inst_reg, buf_inst_next;
  logic [31:0]   buf_addr_reg, buf_addr_next;
  logic          id_valid_reg, id_valid_next;
  logic [31:0]   id_inst_reg, id_inst_next;
  logic [31:0]   id_pc4_reg, id_pc4_next;

  logic [31:0]   redirect_tgt;
  logic [31:0]   req_addr_inc;
  logic [31:0]   buf_addr_inc;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign req_addr_inc = req_addr_reg + 32'd4;
  assign buf_addr_inc = buf_addr_reg + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      req_addr_reg <= RESET_PC;
      target_reg   <= '0;
      discard_reg  <= 1'b0;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
      buf_inst_reg <= '0;
      buf_addr_reg <= '0;
      id_valid_reg <= 1'b0;
      id_inst_reg  <= '0;
      id_pc4_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      req_addr_reg <= req_addr_next;
      target_reg   <= target_next;
      discard_reg  <= discard_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
      buf_inst_reg <= buf_inst_next;
      buf_addr_reg <= buf_addr_next;
      id_valid_reg <= id_valid_next;
      id_inst_reg  <= id_inst_next;
      id_pc4_reg   <= id_pc4_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    req_addr_next = req_addr_reg;
    target_next   = target_reg;
    discard_next  = discard_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = timeout_reg;
    buf_inst_next = buf_inst_reg;
    buf_addr_next = buf_addr_reg;
    id_valid_next = id_valid_reg;
    id_inst_next  = id_inst_reg;
    id_pc4_next   = id_pc4_reg;

    case (state_reg)
      IDLE: begin
        // Any ack seen here belongs to a request abandoned by reset.
        state_next = REQ;
        if (redirect) begin
          req_addr_next = redirect_tgt;
          id_valid_next = 1'b0;
        end
      end

      REQ: begin
        if (redirect) begin
          id_valid_next = 1'b0;
          wait_cnt_next = '0;
          if (bus.imem_ack) begin
            // The word in flight is dropped; the target can be fetched at once.
            req_addr_next = redirect_tgt;
            discard_next  = 1'b0;
          end else begin
            // imem_addr must stay stable until the ack, so park the target
            // and throw away the word that eventually comes back.
            discard_next = 1'b1;
            target_next  = redirect_tgt;
          end
        end else if (bus.imem_ack) begin
          wait_cnt_next = '0;
          if (discard_reg) begin
            discard_next  = 1'b0;
            req_addr_next = target_reg;
            if (!stall) id_valid_next = 1'b0;
          end else if (!stall) begin
            id_inst_next  = bus.imem_rdata;
            id_pc4_next   = req_addr_inc;
            id_valid_next = 1'b1;
            req_addr_next = req_addr_inc;
          end else begin
            buf_inst_next = bus.imem_rdata;
            buf_addr_next = req_addr_reg;
            state_next    = HOLD;
          end
        end else begin
          if (wait_cnt_reg != LIMIT) wait_cnt_next = wait_cnt_reg + CW'(1);
          if (!stall) id_valid_next = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          // Leaving HOLD abandons the parked word.
          req_addr_next = redirect_tgt;
          id_valid_next = 1'b0;
          state_next    = REQ;
        end else if (!stall) begin
          id_inst_next  = buf_inst_reg;
          id_pc4_next   = buf_addr_inc;
          id_valid_next = 1'b1;
          req_addr_next = buf_addr_inc;
          state_next    = REQ;
        end
      end

      default: state_next = IDLE;
    endcase

    // wait_cnt saturates at LIMIT, so equality marks the timeout point.
    if (wait_cnt_next == LIMIT) timeout_next = 1'b1;
  end

  assign bus.imem_req   = (state_reg == REQ);
  assign bus.imem_addr  = req_addr_reg;
  assign id_valid       = id_valid_reg;
  assign id_inst        = id_inst_reg;
  assign id_opcode      = id_inst_reg[31:26];
  assign id_pc4         = id_pc4_reg;
  assign fetch_timeout  = timeout_reg;

endmodule
